alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares one single-cycle `alu` instance between two requesters, for example the integer execute path and the branch-compare path of a multi-issue or multi-cycle core. Each requester uses a valid/ready request handshake. A round-robin arbiter grants one request at a time. The block latches the granted operands and drives them into the ALU for one execute cycle. It then captures result and flags into a response register that is held until the consumer accepts it. Only one operation is in flight at any time.

## Interface
- `DATA_WIDTH`, 32, operand/result width; must match the attached `alu`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `reqN_valid`  in  1  (N = 0, 1) requester N presents an operation.
- `reqN_ready`  out  1  request N accepted this cycle (a handshake occurs when valid && ready).
- `reqN_a`, `reqN_b`  in  DATA_WIDTH  operands.
- `reqN_instr_type`  in  rv32i_base_instr_type  instruction format.
- `reqN_opcode`  in  rv32i_base_instr  decoded instruction.
- `alu_a`, `alu_b`  out  DATA_WIDTH  latched operands to the ALU.
- `alu_instr_type`, `alu_opcode`  out  enum  latched control to the ALU.
- `alu_result`  in  DATA_WIDTH  ALU result.
- `alu_eq`, `alu_lt`, `alu_ltu`  in  1  ALU compare flags.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  1  index of the requester that owns the response.
- `rsp_result`  out  DATA_WIDTH  captured result.
- `rsp_eq`, `rsp_lt`, `rsp_ltu`  out  1  captured flags.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Arbitrate among asserted `reqN_valid`.
  - Assert `reqN_ready` for the granted requester only. The value is combinational from state and valids, with no dependence on `rsp_ready`.
  - On handshake: latch a, b, instr_type, opcode and the id into the operand register, then go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC (exactly one cycle):
  - `alu_*` outputs reflect the operand register.
  - At the clock edge, capture `alu_result`, `alu_eq` and `alu_ltu` into the response register, then go to RESP.
  - `rsp_lt` captures `alu_lt` only when the opcode is SUB, SLT, SLTI, SLTU, SLTIU or instr_type is B. Otherwise it captures 0, because the ALU does not drive `lt` for other operations.
- RESP:
  - `rsp_valid`=1; all `rsp_*` stay stable.
  - On `rsp_valid && rsp_ready`, return to IDLE.
  - Both `reqN_ready`=0 throughout RESP.
- Arbitration:
  - A 1-bit `last_grant` register holds the last winner.
  - When both requesters are valid, the one not equal to `last_grant` wins.
  - When only one is valid, it wins.
  - `last_grant` updates only on a request handshake.
- Request-side rules:
  - A requester may drop valid without a handshake; this has no effect.
  - Operand changes while not granted are ignored.
- `alu_*` outputs are driven from the operand register in every state. The ALU is otherwise unobserved outside EXEC.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - state=IDLE, `last_grant`=1, so requester 0 wins the first tie.
  - Operand register and response register = 0.
  - `rsp_valid`=0, `rsp_id`=0, and all `rsp_*` flags = 0.
  - `alu_a`=`alu_b`=0, `alu_instr_type` and `alu_opcode` = enum value 0.
- Latency: a request handshake on cycle T gives EXEC on T+1 and `rsp_valid`=1 on T+2.
- Throughput: at best one operation per 3 cycles (accept, execute, respond with `rsp_ready`=1 on T+2, IDLE on T+3).
- Back-pressure: RESP holds indefinitely while `rsp_ready`=0; no requester can be accepted during that time.
- A request valid in IDLE while the response is being consumed (RESP → IDLE edge) is not accepted until the next IDLE cycle.
- Reset asserted mid-EXEC or mid-RESP: the in-flight operation is discarded, no response is produced, and the block restarts in IDLE after `rst_n` rises.
- `rsp_ready` asserted outside RESP is ignored.
- Width: no arithmetic is done in this block; the result is a DATA_WIDTH-bit pass-through.

## Test plan
- Single request, no contention:
  - Stimulus: reset, then req0 ADD/R with a=5, b=7.
  - Required: `req0_ready`=1 in the same cycle; `rsp_valid` two cycles later with `rsp_result`=12, `rsp_id`=0, `rsp_eq`=0, `rsp_lt`=0.
- Tie after reset, then alternation:
  - Stimulus: req0 SUB with a=3, b=5 and req1 XOR with a=0xF0, b=0xFF, both valid in the first cycle.
  - Required: req0 is granted first, with `rsp_result`=0xFFFFFFFE, `rsp_lt`=1, `rsp_ltu`=1, `rsp_eq`=0. Then req1 is granted, with `rsp_result`=0x0F, `rsp_lt`=0, `rsp_id`=1.
- Fairness:
  - Stimulus: both requesters valid continuously for 6 operations, `rsp_ready`=1.
  - Required: `rsp_id` sequence 0,1,0,1,0,1; each grant spaced 3 cycles apart.
- Back-pressure:
  - Stimulus: BEQ/B with a=b=0x1234, then `rsp_ready`=0 for 4 cycles.
  - Required: `rsp_valid` and all `rsp_*` stable, with `rsp_eq`=1 and `rsp_result`=0; both `reqN_ready`=0 until `rsp_ready`=1, then IDLE the cycle after.
- Compare immediates:
  - Stimulus: SLTIU/I with a=1, b=0xFFFFFFFF.
  - Required: `rsp_result`=1, `rsp_ltu`=1.
  - Stimulus: SLTI with a=1, b=0xFFFFFFFF.
  - Required: `rsp_result`=0, `rsp_lt`=0.
  - Stimulus: ORI.
  - Required: `rsp_lt` forced to 0.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 during EXEC.
  - Required: all outputs immediately at reset values and no `rsp_valid` afterwards. After release, a tie is granted to requester 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one single-cycle ALU between two requesters
package rv32i_pkg;
  typedef enum logic [2:0] {
    R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE
  } rv32i_base_instr_type;

  typedef enum logic [5:0] {
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU, SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    FENCE, ECALL, EBREAK
  } rv32i_base_instr;
endpackage

module alu_share_arbiter
  import rv32i_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  rv32i_base_instr_type  req0_instr_type,
  input  rv32i_base_instr       req0_opcode,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  rv32i_base_instr_type  req1_instr_type,
  input  rv32i_base_instr       req1_opcode,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output rv32i_base_instr_type  alu_instr_type,
  output rv32i_base_instr       alu_opcode,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_eq,
  input  logic                  alu_lt,
  input  logic                  alu_ltu,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_eq,
  output logic                  rsp_lt,
  output logic                  rsp_ltu
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  rv32i_base_instr_type  op_type_q, op_type_d;
  rv32i_base_instr       op_code_q, op_code_d;
  logic                  op_id_q, op_id_d;
  logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                  rsp_id_q, rsp_id_d;
  logic                  rsp_eq_q, rsp_eq_d;
  logic                  rsp_lt_q, rsp_lt_d;
  logic                  rsp_ltu_q, rsp_ltu_d;
  logic                  grant_id;
  logic                  lt_valid;

  // On a tie the requester that did not win last time gets the grant.
  assign grant_id = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

  // The ALU only drives lt for subtract, set-less-than and branch compares.
  assign lt_valid = (op_code_q inside {SUB, SLT, SLTI, SLTU, SLTIU}) || (op_type_q == B_TYPE);

  // Next-state, grant and register-load logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_type_d    = op_type_q;
    op_code_d    = op_code_q;
    op_id_d      = op_id_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
    rsp_eq_d     = rsp_eq_q;
    rsp_lt_d     = rsp_lt_q;
    rsp_ltu_d    = rsp_ltu_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready   = ~grant_id;
          req1_ready   = grant_id;
          op_a_d       = grant_id ? req1_a : req0_a;
          op_b_d       = grant_id ? req1_b : req0_b;
          op_type_d    = grant_id ? req1_instr_type : req0_instr_type;
          op_code_d    = grant_id ? req1_opcode : req0_opcode;
          op_id_d      = grant_id;
          last_grant_d = grant_id;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_id_d     = op_id_q;
        rsp_eq_d     = alu_eq;
        rsp_lt_d     = alu_lt & lt_valid;
        rsp_ltu_d    = alu_ltu;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand and response registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_type_q    <= R_TYPE;
      op_code_q    <= LUI;
      op_id_q      <= 1'b0;
      rsp_result_q <= '0;
      rsp_id_q     <= 1'b0;
      rsp_eq_q     <= 1'b0;
      rsp_lt_q     <= 1'b0;
      rsp_ltu_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_type_q    <= op_type_d;
      op_code_q    <= op_code_d;
      op_id_q      <= op_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
      rsp_eq_q     <= rsp_eq_d;
      rsp_lt_q     <= rsp_lt_d;
      rsp_ltu_q    <= rsp_ltu_d;
    end
  end

  assign alu_a          = op_a_q;
  assign alu_b          = op_b_q;
  assign alu_instr_type = op_type_q;
  assign alu_opcode     = op_code_q;
  assign rsp_valid      = (state_q == RESP);
  assign rsp_id         = rsp_id_q;
  assign rsp_result     = rsp_result_q;
  assign rsp_eq         = rsp_eq_q;
  assign rsp_lt         = rsp_lt_q;
  assign rsp_ltu        = rsp_ltu_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
  import rv32i_pkg::*;

  localparam int DW = 32;

  logic                 clk, rst_n;
  logic                 req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0]        req0_a, req0_b, req1_a, req1_b;
  rv32i_base_instr_type req0_instr_type, req1_instr_type, alu_instr_type;
  rv32i_base_instr      req0_opcode, req1_opcode, alu_opcode;
  logic [DW-1:0]        alu_a, alu_b, alu_result;
  logic                 alu_eq, alu_lt, alu_ltu;
  logic                 rsp_valid, rsp_ready, rsp_id, rsp_eq, rsp_lt, rsp_ltu;
  logic [DW-1:0]        rsp_result;

  int n_pass, n_total;
  int g_id[6], g_cyc[6], r_id[6];
  logic [31:0] r_res[6];
  int ng, nr;

  alu_share_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_instr_type(req0_instr_type), .req0_opcode(req0_opcode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_instr_type(req1_instr_type), .req1_opcode(req1_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_instr_type(alu_instr_type), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_eq(alu_eq), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_eq(rsp_eq), .rsp_lt(rsp_lt), .rsp_ltu(rsp_ltu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in single-cycle ALU; lt is always driven so the response masking is visible.
  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      ADD, ADDI:   alu_result = alu_a + alu_b;
      SUB:         alu_result = alu_a - alu_b;
      XOR, XORI:   alu_result = alu_a ^ alu_b;
      OR, ORI:     alu_result = alu_a | alu_b;
      AND, ANDI:   alu_result = alu_a & alu_b;
      SLT, SLTI:   alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      SLTU, SLTIU: alu_result = {31'b0, alu_a < alu_b};
      default:     alu_result = '0;
    endcase
  end
  assign alu_eq  = (alu_a == alu_b);
  assign alu_lt  = ($signed(alu_a) < $signed(alu_b));
  assign alu_ltu = (alu_a < alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_total++;
    if (obs === expd) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expd);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic present(input bit id, input rv32i_base_instr op, input rv32i_base_instr_type it,
                         input logic [31:0] a, input logic [31:0] b);
    if (!id) begin
      req0_valid = 1'b1; req0_opcode = op; req0_instr_type = it; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_opcode = op; req1_instr_type = it; req1_a = a; req1_b = b;
    end
  endtask

  // Issue one operation alone and stop in the first RESP cycle.
  task automatic run_op(input bit id, input rv32i_base_instr op, input rv32i_base_instr_type it,
                        input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    present(id, op, it, a, b);
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 8) begin
      step();
      n++;
    end
    check("grant_wait", 32'(n < 8), 32'd1);
    step();
    if (!id) req0_valid = 1'b0; else req1_valid = 1'b0;
    step();
    check("rsp_valid_up", 32'(rsp_valid), 32'd1);
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_valid_down", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_pass = 0; n_total = 0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    req0_opcode = LUI; req1_opcode = LUI; req0_instr_type = R_TYPE; req1_instr_type = R_TYPE;
    rst_n = 0;
    step(); step();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_flags", 32'({rsp_eq, rsp_lt, rsp_ltu}), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("rst_alu_type", 32'(alu_instr_type), 32'd0);
    rst_n = 1;
    step();

    // Single request, no contention
    present(0, ADD, R_TYPE, 5, 7);
    #1;
    check("t1_ready0", 32'(req0_ready), 32'd1);
    check("t1_ready1", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 0;
    check("t1_exec_a", alu_a, 32'd5);
    check("t1_exec_b", alu_b, 32'd7);
    check("t1_exec_op", 32'(alu_opcode), 32'(ADD));
    check("t1_exec_nvalid", 32'(rsp_valid), 32'd0);
    step();
    check("t1_valid", 32'(rsp_valid), 32'd1);
    check("t1_result", rsp_result, 32'd12);
    check("t1_id", 32'(rsp_id), 32'd0);
    check("t1_eq", 32'(rsp_eq), 32'd0);
    check("t1_lt", 32'(rsp_lt), 32'd0);
    release_rsp();

    // Tie after reset, then alternation
    rst_n = 0; step(); rst_n = 1; step();
    present(0, SUB, R_TYPE, 3, 5);
    present(1, XOR, R_TYPE, 32'hF0, 32'hFF);
    #1;
    check("t2_ready0", 32'(req0_ready), 32'd1);
    check("t2_ready1", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 0;
    step();
    check("t2a_result", rsp_result, 32'hFFFF_FFFE);
    check("t2a_lt", 32'(rsp_lt), 32'd1);
    check("t2a_ltu", 32'(rsp_ltu), 32'd1);
    check("t2a_eq", 32'(rsp_eq), 32'd0);
    check("t2a_id", 32'(rsp_id), 32'd0);
    check("t2a_resp_ready1", 32'(req1_ready), 32'd0);
    release_rsp();
    check("t2b_ready1", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 0;
    step();
    check("t2b_result", rsp_result, 32'h0000_000F);
    check("t2b_lt", 32'(rsp_lt), 32'd0);
    check("t2b_id", 32'(rsp_id), 32'd1);
    release_rsp();

    // Fairness under continuous contention
    present(0, ADD, R_TYPE, 1, 2);
    present(1, SUB, R_TYPE, 10, 4);
    rsp_ready = 1;
    #1;
    ng = 0; nr = 0;
    for (int c = 0; c < 40 && nr < 6; c++) begin
      if (ng < 6 && (req0_ready || req1_ready)) begin
        g_id[ng] = int'(req1_ready); g_cyc[ng] = c; ng++;
      end
      if (rsp_valid && nr < 6) begin
        r_id[nr] = int'(rsp_id); r_res[nr] = rsp_result; nr++;
      end
      step();
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    check("fair_grants", 32'(ng), 32'd6);
    check("fair_rsps", 32'(nr), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check("fair_gid", 32'(g_id[i]), 32'(i % 2));
      check("fair_rid", 32'(r_id[i]), 32'(i % 2));
      check("fair_res", r_res[i], (i % 2 == 1) ? 32'd6 : 32'd3);
      if (i > 0) check("fair_gap", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
    end
    step();

    // Back-pressure
    run_op(1, BEQ, B_TYPE, 32'h1234, 32'h1234);
    present(0, ADD, R_TYPE, 1, 1);
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_eq", 32'(rsp_eq), 32'd1);
      check("bp_result", rsp_result, 32'd0);
      check("bp_id", 32'(rsp_id), 32'd1);
      check("bp_ready0", 32'(req0_ready), 32'd0);
      check("bp_ready1", 32'(req1_ready), 32'd0);
      step();
    end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    check("bp_idle_valid", 32'(rsp_valid), 32'd0);
    check("bp_idle_ready0", 32'(req0_ready), 32'd1);
    req0_valid = 0;
    step();

    // Compare immediates and lt masking
    run_op(0, SLTIU, I_TYPE, 1, 32'hFFFF_FFFF);
    check("sltiu_result", rsp_result, 32'd1);
    check("sltiu_ltu", 32'(rsp_ltu), 32'd1);
    release_rsp();
    run_op(0, SLTI, I_TYPE, 1, 32'hFFFF_FFFF);
    check("slti_result", rsp_result, 32'd0);
    check("slti_lt", 32'(rsp_lt), 32'd0);
    release_rsp();
    run_op(1, ORI, I_TYPE, 32'hFFFF_FFFF, 1);
    check("ori_result", rsp_result, 32'hFFFF_FFFF);
    check("ori_lt", 32'(rsp_lt), 32'd0);
    release_rsp();
    run_op(1, BLT, B_TYPE, 32'hFFFF_FFFF, 1);
    check("blt_lt", 32'(rsp_lt), 32'd1);
    check("blt_ltu", 32'(rsp_ltu), 32'd0);
    release_rsp();

    // Reset during EXEC
    present(0, ADD, R_TYPE, 9, 9);
    #1;
    check("rx_ready0", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 0;
    check("rx_exec_a", alu_a, 32'd9);
    rst_n = 0;
    #1;
    check("rx_alu_a", alu_a, 32'd0);
    check("rx_alu_op", 32'(alu_opcode), 32'd0);
    check("rx_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rx_rsp_result", rsp_result, 32'd0);
    step(); step();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      check("rx_no_rsp", 32'(rsp_valid), 32'd0);
      step();
    end
    present(0, ADD, R_TYPE, 2, 3);
    present(1, SUB, R_TYPE, 2, 3);
    #1;
    check("rx_tie_ready0", 32'(req0_ready), 32'd1);
    check("rx_tie_ready1", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 0; req1_valid = 0;
    step();
    check("rx_rsp_id", 32'(rsp_id), 32'd0);
    check("rx_result", rsp_result, 32'd5);
    release_rsp();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
